nvdla_csb_master: RTL
=====================

// Module: nvdla_csb_master
// PURPOSE
//  Initiator side of the NVDLA configuration-space bus (CSB). Accepts single register
//  read/write requests from the HWPE control slave and drives csb2nvdla_* toward the core.
//  Collects nvdla2csb read data / write-complete responses and returns exactly one
//  response per request to the control side. One transaction outstanding; timeout-protected.
// PARAMETERS
//  ADDR_WIDTH      16    CSB word address width
//  DATA_WIDTH      32    CSB data width
//  TIMEOUT_CYCLES  1024  max cycles in WAIT before error response (>=2)
//  CNT_WIDTH       $clog2(TIMEOUT_CYCLES)  timeout counter width (derived)
// PORTS
//  clk_i                    in   1           clock; the single clock of the block
//  rst_ni                   in   1           reset, asynchronous, active-low
//  clear_i                  in   1           synchronous soft clear / abort
//  req_valid_i              in   1           host request valid
//  req_ready_o              out  1           host request ready (high only in IDLE)
//  req_addr_i               in   ADDR_WIDTH  register word address
//  req_wdata_i              in   DATA_WIDTH  write data
//  req_write_i              in   1           1=write, 0=read
//  req_nposted_i            in   1           write expects wr_complete
//  rsp_valid_o              out  1           host response valid
//  rsp_ready_i              in   1           host response ready
//  rsp_rdata_o              out  DATA_WIDTH  read data (0 for writes/errors)
//  rsp_error_o              out  1           1=timeout
//  busy_o                   out  1           state != IDLE
//  stray_o                  out  1           sticky: response arrived outside WAIT
//  csb2nvdla_valid_o        out  1           CSB request valid
//  csb2nvdla_ready_i        in   1           CSB request ready
//  csb2nvdla_addr_o         out  ADDR_WIDTH  CSB address
//  csb2nvdla_wdat_o         out  DATA_WIDTH  CSB write data
//  csb2nvdla_write_o        out  1           CSB write flag
//  csb2nvdla_nposted_o      out  1           CSB non-posted flag
//  nvdla2csb_valid_i        in   1           read-data pulse (no backpressure)
//  nvdla2csb_data_i         in   DATA_WIDTH  read data
//  nvdla2csb_wr_complete_i  in   1           non-posted write complete pulse
// BEHAVIOUR
//  Reset: all outputs 0, state IDLE, counter 0, stray_o 0, capture regs 0.
//  FSM states IDLE, REQ, WAIT, RESP.
//  IDLE: req_ready_o=1. On req_valid_i: register addr/wdata/write/nposted -> REQ.
//   nposted forced 0 for reads.
//  REQ: csb2nvdla_valid_o=1; addr/wdat/write/nposted stable from registers until ready.
//   On csb2nvdla_ready_i: posted write -> RESP(rdata=0,error=0); read or nposted write -> WAIT, counter=0.
//  WAIT: read completes on nvdla2csb_valid_i (capture data); nposted write on
//   nvdla2csb_wr_complete_i. Either -> RESP, error=0. Wrong-type pulse sets stray_o, ignored.
//   Counter +1 per cycle; at TIMEOUT_CYCLES-1 with no response -> RESP, error=1, rdata=0.
//   Response on the timeout cycle wins (normal completion).
//  RESP: rsp_valid_o=1, rdata/error held until rsp_ready_i -> IDLE. New request taken next cycle.
//  Latency: req handshake cycle t, csb valid t+1; response pulse at k -> rsp_valid_o at k+1.
//  Responses while in IDLE/REQ/RESP (incl. late after timeout): dropped, stray_o=1.
//  clear_i: highest priority after reset; -> IDLE next cycle, drops csb/rsp valid, counter=0,
//   stray_o=0. Software abort only; an in-flight CSB transfer is abandoned.
//  Reset mid-transaction: immediate return to reset values, no response emitted.
// TESTING
//  Read 0x0A00, ready same cycle, data 0x12345678 after 3 cyc -> rsp rdata 0x12345678, error 0.
//  Posted write 0x1000=0xCAFE, ready held low 5 cyc -> csb fields stable 5 cyc; rsp next cycle, no wait.
//  Nposted write, wr_complete after 10 cyc -> rsp error 0; nvdla2csb_valid during WAIT -> stray_o=1.
//  Read with no response, TIMEOUT_CYCLES=16 -> rsp error=1, rdata=0 exactly 16 cyc after WAIT entry; late pulse -> stray_o.
//  Read done, rsp_ready_i low 4 cyc -> rsp stable 4 cyc, req_ready_o 0; back-to-back second read correct.
//  clear_i in WAIT and rst_ni low in REQ -> all valids 0 next cycle/immediately; later request normal.

Source files
------------

// File: rtl/nvdla_csb_master.sv
// CSB initiator: turns single host register requests into csb2nvdla transfers and
// returns exactly one response per request, with a WAIT-state timeout.
module nvdla_csb_master #(
  parameter int unsigned ADDR_WIDTH     = 16,
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  clear_i,
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic [ADDR_WIDTH-1:0] req_addr_i,
  input  logic [DATA_WIDTH-1:0] req_wdata_i,
  input  logic                  req_write_i,
  input  logic                  req_nposted_i,
  output logic                  rsp_valid_o,
  input  logic                  rsp_ready_i,
  output logic [DATA_WIDTH-1:0] rsp_rdata_o,
  output logic                  rsp_error_o,
  output logic                  busy_o,
  output logic                  stray_o,
  output logic                  csb2nvdla_valid_o,
  input  logic                  csb2nvdla_ready_i,
  output logic [ADDR_WIDTH-1:0] csb2nvdla_addr_o,
  output logic [DATA_WIDTH-1:0] csb2nvdla_wdat_o,
  output logic                  csb2nvdla_write_o,
  output logic                  csb2nvdla_nposted_o,
  input  logic                  nvdla2csb_valid_i,
  input  logic [DATA_WIDTH-1:0] nvdla2csb_data_i,
  input  logic                  nvdla2csb_wr_complete_i
);

  localparam int unsigned CNT_WIDTH = $clog2(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_RESP} state_e;

  state_e                state_q;
  logic [CNT_WIDTH-1:0]  cnt_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdat_q;
  logic                  write_q;
  logic                  nposted_q;
  logic                  csb_valid_q;
  logic                  req_ready_q;
  logic                  rsp_valid_q;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic                  error_q;
  logic                  busy_q;
  logic                  stray_q;

  logic any_pulse;
  logic rd_done;
  logic wr_done;
  logic wrong_pulse;

  assign any_pulse   = nvdla2csb_valid_i | nvdla2csb_wr_complete_i;
  assign rd_done     = ~write_q & nvdla2csb_valid_i;
  assign wr_done     = write_q & nvdla2csb_wr_complete_i;
  assign wrong_pulse = (~write_q & nvdla2csb_wr_complete_i) | (write_q & nvdla2csb_valid_i);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      addr_q      <= '0;
      wdat_q      <= '0;
      write_q     <= 1'b0;
      nposted_q   <= 1'b0;
      csb_valid_q <= 1'b0;
      req_ready_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      rdata_q     <= '0;
      error_q     <= 1'b0;
      busy_q      <= 1'b0;
      stray_q     <= 1'b0;
    end else if (clear_i) begin
      // Abort: any in-flight CSB transfer is abandoned without a response
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      csb_valid_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      req_ready_q <= 1'b1;
      busy_q      <= 1'b0;
      stray_q     <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          req_ready_q <= 1'b1;
          if (any_pulse) stray_q <= 1'b1;
          if (req_valid_i && req_ready_q) begin
            addr_q      <= req_addr_i;
            wdat_q      <= req_wdata_i;
            write_q     <= req_write_i;
            nposted_q   <= req_write_i & req_nposted_i;
            csb_valid_q <= 1'b1;
            req_ready_q <= 1'b0;
            busy_q      <= 1'b1;
            state_q     <= S_REQ;
          end
        end
        S_REQ: begin
          if (any_pulse) stray_q <= 1'b1;
          if (csb2nvdla_ready_i) begin
            csb_valid_q <= 1'b0;
            if (write_q && !nposted_q) begin
              rsp_valid_q <= 1'b1;
              rdata_q     <= '0;
              error_q     <= 1'b0;
              state_q     <= S_RESP;
            end else begin
              cnt_q   <= '0;
              state_q <= S_WAIT;
            end
          end
        end
        S_WAIT: begin
          if (wrong_pulse) stray_q <= 1'b1;
          // A response on the timeout cycle still counts as a normal completion
          if (rd_done || wr_done) begin
            rsp_valid_q <= 1'b1;
            rdata_q     <= rd_done ? nvdla2csb_data_i : '0;
            error_q     <= 1'b0;
            state_q     <= S_RESP;
          end else if (cnt_q == CNT_WIDTH'(TIMEOUT_CYCLES - 1)) begin
            rsp_valid_q <= 1'b1;
            rdata_q     <= '0;
            error_q     <= 1'b1;
            state_q     <= S_RESP;
          end else begin
            cnt_q <= cnt_q + CNT_WIDTH'(1);
          end
        end
        S_RESP: begin
          if (any_pulse) stray_q <= 1'b1;
          if (rsp_ready_i) begin
            rsp_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            req_ready_q <= 1'b1;
            state_q     <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign req_ready_o         = req_ready_q;
  assign rsp_valid_o         = rsp_valid_q;
  assign rsp_rdata_o         = rdata_q;
  assign rsp_error_o         = error_q;
  assign busy_o              = busy_q;
  assign stray_o             = stray_q;
  assign csb2nvdla_valid_o   = csb_valid_q;
  assign csb2nvdla_addr_o    = addr_q;
  assign csb2nvdla_wdat_o    = wdat_q;
  assign csb2nvdla_write_o   = write_q;
  assign csb2nvdla_nposted_o = nposted_q;

endmodule
